mc_ctrl_fsm: RTL

Parametrised multicycle control unit for the RISC core. It sequences fetch, decode, execute, memory and write-back, and drives every datapath mux select and enable from a single explicit state register. Beyond the earlier controller, it adds three features: flag-conditional ALU ops, a variable-latency memory handshake, and load/store-multiple over a register bitmask of width NREG. It sits between the instruction register/flags and the datapath (ALU, register file, PC, temp address register, memory port).

---
 rtl/mc_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back and
// decodes every datapath select and enable from one explicit state register.
module mc_ctrl_fsm #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] ir,
  input  logic              mem_ready,
  input  logic              alu_zero,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic              ir_we,
  output logic              pc_we,
  output logic              rf_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic              tmp_we,
  output logic              tmp_inc,
  output logic [1:0]        pc_src,
  output logic [1:0]        alu_a_sel,
  output logic [1:0]        alu_b_sel,
  output logic [1:0]        alu_op,
  output logic [1:0]        cz_we,
  output logic [REG_AW-1:0] rf_wadd,
  output logic [1:0]        rf_wsrc,
  output logic              mem_addr_sel,
  output logic              illegal_op,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_MLOOP  = 4'd5,
    S_BRANCH = 4'd6,
    S_TRAP   = 4'd7
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADI = 4'd1;
  localparam logic [3:0] OP_NDU = 4'd2;
  localparam logic [3:0] OP_LHI = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SW  = 4'd5;
  localparam logic [3:0] OP_LM  = 4'd6;
  localparam logic [3:0] OP_SM  = 4'd7;
  localparam logic [3:0] OP_JAL = 4'd8;
  localparam logic [3:0] OP_JLR = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd12;

  state_t            state, state_next;
  logic [NREG-1:0]   pending, pending_next;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] ra, rb, rc, low_idx;
  logic              legal, cond_ok;

  assign opcode = ir[WORD_W-1 -: 4];
  assign ra     = ir[11 -: REG_AW];
  assign rb     = ir[8 -: REG_AW];
  assign rc     = ir[5 -: REG_AW];

  // Opcode legality and ADD/NDU flag condition in ir[1:0].
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_ADD, OP_ADI, OP_NDU, OP_LHI, OP_LW, OP_SW, OP_LM, OP_SM,
      OP_JAL, OP_JLR, OP_BEQ: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    cond_ok = 1'b1;
    case (ir[1:0])
      2'b00:   cond_ok = 1'b1;
      2'b10:   cond_ok = flag_c;
      2'b01:   cond_ok = flag_z;
      default: cond_ok = 1'b0;
    endcase
  end

  // Lowest set pending bit: scanning downward leaves the smallest index.
  always_comb begin
    low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = REG_AW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      S_FETCH: if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
          state_next = S_TRAP;
        end else begin
          case (opcode)
            OP_ADD, OP_NDU: state_next = cond_ok ? S_EXEC : S_FETCH;
            OP_JAL, OP_JLR: state_next = S_WB;
            OP_LM, OP_SM: begin
              state_next   = S_MLOOP;
              pending_next = ir[NREG-1:0];
            end
            default:        state_next = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM;
          OP_BEQ:       state_next = alu_zero ? S_BRANCH : S_FETCH;
          default:      state_next = S_WB;
        endcase
      end
      S_MEM: if (mem_ready) state_next = (opcode == OP_LW) ? S_WB : S_FETCH;
      S_MLOOP: begin
        if (pending == '0) begin
          state_next = S_FETCH;
        end else if (mem_ready) begin
          pending_next = pending & (pending - NREG'(1));
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Output decode; reset forces every output low regardless of state.
  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    tmp_we       = 1'b0;
    tmp_inc      = 1'b0;
    pc_src       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 2'd0;
    alu_op       = 2'd0;
    cz_we        = 2'b00;
    rf_wadd      = '0;
    rf_wsrc      = 2'd0;
    mem_addr_sel = 1'b0;
    illegal_op   = 1'b0;
    state_o      = 4'd0;
    if (!reset) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_b_sel = 2'd1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_DECODE: begin
          if (opcode == OP_LM || opcode == OP_SM) tmp_we = 1'b1;
        end
        S_EXEC: begin
          alu_a_sel = 2'd1;
          case (opcode)
            OP_ADD: cz_we = 2'b11;
            OP_ADI: begin
              alu_b_sel = 2'd2;
              cz_we     = 2'b11;
            end
            OP_NDU: begin
              alu_op = 2'd1;
              cz_we  = 2'b01;
            end
            OP_LW, OP_SW: begin
              alu_b_sel = 2'd2;
              tmp_we    = 1'b1;
            end
            OP_BEQ:  alu_op = 2'd2;
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_SW);
        end
        S_WB: begin
          rf_we = 1'b1;
          case (opcode)
            OP_JAL, OP_JLR: begin
              rf_wadd = ra;
              rf_wsrc = 2'd3;
              pc_src  = (opcode == OP_JAL) ? 2'd2 : 2'd1;
              pc_we   = 1'b1;
            end
            OP_LW: begin
              rf_wadd = ra;
              rf_wsrc = 2'd1;
            end
            OP_LHI: begin
              rf_wadd = ra;
              rf_wsrc = 2'd2;
            end
            OP_ADI:  rf_wadd = rb;
            default: rf_wadd = rc;
          endcase
        end
        S_MLOOP: begin
          if (pending != '0) begin
            rf_wadd      = low_idx;
            rf_wsrc      = (opcode == OP_LM) ? 2'd1 : 2'd0;
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opcode == OP_SM);
            if (mem_ready) begin
              rf_we   = (opcode == OP_LM);
              tmp_inc = 1'b1;
            end
          end
        end
        S_BRANCH: begin
          pc_src = 2'd2;
          pc_we  = 1'b1;
        end
        S_TRAP:  illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
